hex_display_ctrl: RTL
=====================

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 8, number of hex digits driven; legal range 1..16.
REQ-002 Parameter MULTIPLEXED, default 0, 0 = static per-digit segment outputs, 1 = time-multiplexed single segment bus.
REQ-003 Parameter SCAN_DIV, default 16384, clock cycles each digit is selected in multiplexed mode; SCAN_DIV >= GUARD+2.
REQ-004 Parameter GUARD, default 2, cycles with all digit selects off after each digit change.
REQ-005 Parameter BLINK_BITS, default 24, width of free-running blink counter.
REQ-006 Parameter SEG_ACTIVE_LOW, default 1, 1 = segment bit 0 lights the segment.
REQ-007 clk  input  1  system clock; the only clock.
REQ-008 reset_in  input  1  reset, synchronous, active-high.
REQ-009 value_in  input  4*DIGITS  nibble per digit, digit 0 in bits [3:0].
REQ-010 load  input  1  single-cycle strobe capturing value_in, blank_mask, blink_mask.
REQ-011 blank_mask  input  DIGITS  1 = digit forced dark.
REQ-012 blink_mask  input  DIGITS  1 = digit blinks.
REQ-013 lz_blank  input  1  leading-zero suppression enable, sampled every cycle.
REQ-014 seg_static  output  7*DIGITS  segments {g..a} per digit, digit 0 in bits [6:0].
REQ-015 seg_mux  output  7  segments of the currently selected digit.
REQ-016 dig_sel  output  DIGITS  one-hot active-high digit select.
REQ-017 frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

Function
REQ-018 load high at edge N SHALL update the internal value and mask registers at edge N; the corresponding segment outputs SHALL change at edge N+1 (all outputs registered).
REQ-019 load low SHALL hold the registers; there is no back-pressure, and every load is accepted.
REQ-020 Each digit SHALL be decoded 0-F to standard 7-segment glyphs (b and d lowercase), polarity per SEG_ACTIVE_LOW.
REQ-021 A dark digit SHALL drive all segments off (7'h7F when active-low).
REQ-022 With lz_blank=1, the contiguous run of zero nibbles from digit DIGITS-1 downward SHALL be dark; digit 0 SHALL never be dark by suppression.
REQ-023 The blink counter SHALL increment every cycle and wrap at 2^BLINK_BITS; while its MSB is 1, digits with blink_mask set SHALL be dark.
REQ-024 Darkness SHALL be the OR of blank_mask, leading-zero suppression and the blink phase.
REQ-025 MULTIPLEXED=0: seg_static SHALL show all digits; seg_mux SHALL be all off; dig_sel and frame_done SHALL be 0.
REQ-026 MULTIPLEXED=1: seg_static SHALL be all off; a prescaler SHALL count 0..SCAN_DIV-1; at the terminal count, the digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-027 For the first GUARD cycles of each digit slot, dig_sel SHALL be 0; afterwards, the bit for the index SHALL be 1 and seg_mux SHALL carry that digit.
REQ-028 frame_done SHALL pulse on the same edge that the index wraps to 0; with DIGITS=1, it SHALL pulse every SCAN_DIV cycles.
REQ-029 A load coinciding with a digit advance SHALL take effect for the newly selected digit, following the REQ-018 latency.
REQ-030 Values and masks captured by load SHALL persist across any number of scan frames.

Reset
REQ-031 reset_in high at an edge SHALL clear the value, blank and blink registers, blink counter, prescaler and index to 0.
REQ-032 While reset_in is high, seg_static and seg_mux SHALL be all off; dig_sel and frame_done SHALL be 0.
REQ-033 Reset asserted mid-scan SHALL abandon the slot; the first slot after release SHALL be digit 0, with a full GUARD interval.
REQ-034 One cycle after reset release, outputs SHALL display the cleared value ("0" per digit, subject to lz_blank).

Structure
REQ-035 Package hex_display_pkg SHALL hold the 16-entry glyph table, the SEG_OFF constant, and a log2 width function for index/prescaler sizing.
REQ-036 Sub-module hex_seg_lut (4-bit nibble plus dark flag in, 7-bit segments out, combinational) SHALL be instantiated per digit (static) or once (multiplexed).

Verification
REQ-037 Static, DIGITS=8: load value 32'h0000_12AF, lz_blank=0 -> digits 7..0 show 0,0,0,0,1,2,A,F; with lz_blank=1 digits 7..4 are dark.
REQ-038 Static: load value 0, lz_blank=1 -> digits 7..1 are dark and digit 0 shows "0".
REQ-039 Multiplexed, DIGITS=4, SCAN_DIV=8, GUARD=2 -> dig_sel pattern per slot is 0,0,1-hot x6; frame_done pulses every 32 cycles; seg_mux matches each digit.
REQ-040 BLINK_BITS=4, blink_mask=8'h01 -> digit 0 is dark for 8 cycles, then lit for 8 cycles; other digits are unaffected.
REQ-041 Multiplexed: assert reset_in while index=2 -> next cycle all outputs off; after release, dig_sel 0 for 2 cycles, then digit 0 is selected.
REQ-042 load on the index-advance edge with a new value -> the new digit's glyph appears on seg_mux at edge N+1; no stale glyph appears while dig_sel is active.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display controller: glyph table, blank pattern
// and a width helper for the scan counters.
package hex_display_pkg;

  // Active-low all-segments-off pattern
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {g..a} glyphs for 0-F, b and d in lowercase
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bits needed to hold 0..n-1, never less than one
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational nibble-to-segment decoder with a dark override and
// selectable output polarity.
module hex_seg_lut
  import hex_display_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       dark,
  output logic [6:0] seg
);

  // Glyph lookup, polarity applied last so the table stays active-high
  always_comb begin
    seg = SEG_OFF;
    if (dark) begin
      seg = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    end else if (SEG_ACTIVE_LOW != 0) begin
      seg = ~GLYPH[nibble];
    end else begin
      seg = GLYPH[nibble];
    end
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Hex display controller: per-digit static segment outputs or a
// time-multiplexed scan with guard gaps, blanking, blink and zero suppression.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int MULTIPLEXED    = 0,
  parameter int SCAN_DIV       = 16384,
  parameter int GUARD          = 2,
  parameter int BLINK_BITS     = 24,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [6:0]            seg_mux,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam logic [6:0] OFF   = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
  localparam int         IDX_W = clog2w(DIGITS);
  localparam int         PRE_W = clog2w(SCAN_DIV);

  logic [4*DIGITS-1:0]   value_r;
  logic [DIGITS-1:0]     blank_r;
  logic [DIGITS-1:0]     blink_r;
  logic [BLINK_BITS-1:0] blink_cnt_r;
  logic [3:0]            nib_s [DIGITS];
  logic [DIGITS-1:0]     dark_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign nib_s[g] = value_r[4*g +: 4];
  end

  // Captured display content and free-running blink phase
  always_ff @(posedge clk) begin
    if (reset_in) begin
      value_r     <= '0;
      blank_r     <= '0;
      blink_r     <= '0;
      blink_cnt_r <= '0;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_BITS'(1);
      if (load) begin
        value_r <= value_in;
        blank_r <= blank_mask;
        blink_r <= blink_mask;
      end
    end
  end

  // Darkness per digit; run tracks "every digit from the top down to here is zero"
  always_comb begin
    logic run;
    run    = lz_blank;
    dark_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i > 0) begin
        run = run & (nib_s[i] == 4'h0);
      end else begin
        run = 1'b0;
      end
      dark_s[i] = blank_r[i] | run | (blink_r[i] & blink_cnt_r[BLINK_BITS-1]);
    end
  end

  if (MULTIPLEXED == 0) begin : g_static
    logic [7*DIGITS-1:0] seg_dec_s;
    logic [7*DIGITS-1:0] seg_static_r;

    for (genvar g = 0; g < DIGITS; g++) begin : g_lut
      hex_seg_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lut (
        .nibble (nib_s[g]),
        .dark   (dark_s[g]),
        .seg    (seg_dec_s[7*g +: 7])
      );
    end

    // Registered static segment bank
    always_ff @(posedge clk) begin
      if (reset_in) begin
        seg_static_r <= {DIGITS{OFF}};
      end else begin
        seg_static_r <= seg_dec_s;
      end
    end

    assign seg_static = seg_static_r;
    assign seg_mux    = OFF;
    assign dig_sel    = '0;
    assign frame_done = 1'b0;
  end else begin : g_mux
    logic [PRE_W-1:0]  presc_r;
    logic [IDX_W-1:0]  idx_r;
    logic [6:0]        seg_mux_r;
    logic [6:0]        seg_sel_s;
    logic [DIGITS-1:0] dig_sel_r;
    logic [DIGITS-1:0] onehot_s;
    logic              frame_done_r;
    logic [3:0]        sel_nib_s;
    logic              sel_dark_s;

    // Route the currently indexed digit into the single decoder
    always_comb begin
      onehot_s        = '0;
      onehot_s[idx_r] = 1'b1;
      sel_nib_s       = nib_s[idx_r];
      sel_dark_s      = dark_s[idx_r];
    end

    hex_seg_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_lut (
      .nibble (sel_nib_s),
      .dark   (sel_dark_s),
      .seg    (seg_sel_s)
    );

    // Scan prescaler, digit index and guarded select outputs
    always_ff @(posedge clk) begin
      if (reset_in) begin
        presc_r      <= '0;
        idx_r        <= '0;
        seg_mux_r    <= OFF;
        dig_sel_r    <= '0;
        frame_done_r <= 1'b0;
      end else begin
        frame_done_r <= 1'b0;
        if (presc_r == PRE_W'(SCAN_DIV - 1)) begin
          presc_r <= '0;
          if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_r        <= '0;
            frame_done_r <= 1'b1;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end else begin
          presc_r <= presc_r + PRE_W'(1);
        end
        // Selects stay off for the first GUARD cycles of every slot
        if (presc_r >= PRE_W'(GUARD)) begin
          dig_sel_r <= onehot_s;
          seg_mux_r <= seg_sel_s;
        end else begin
          dig_sel_r <= '0;
          seg_mux_r <= OFF;
        end
      end
    end

    assign seg_static = {DIGITS{OFF}};
    assign seg_mux    = seg_mux_r;
    assign dig_sel    = dig_sel_r;
    assign frame_done = frame_done_r;
  end

endmodule
